write_driver: RTL and testbench

Sequencer that fills a contiguous block of register-file entries with a deterministic data pattern, so that the read-address driver has known contents to fetch on ports A/B. It sits on the register-file write port of the pipeline test harness. On a start pulse it issues one write per accepted cycle, honours a stall from the register file, and signals completion so the read side can begin.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/write_driver.sv | 106 ++++++++++
 tb/tb_write_driver.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline test-harness drivers: debug state codes
// and default register-file widths.
package pipeline_pkg;

   localparam logic [3:0] IDLE  = 4'h0;
   localparam logic [3:0] WRITE = 4'h1;
   localparam logic [3:0] DONE  = 4'h2;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   // Encoded with the debug codes so the state register drives the display directly.
   typedef enum logic [3:0] {
      ST_IDLE  = IDLE,
      ST_WRITE = WRITE,
      ST_DONE  = DONE
   } state_e;

endpackage

// File: rtl/write_driver.sv
// Fills NUM_WORDS consecutive register-file entries with an incrementing data
// pattern on each start pulse, honouring write stalls, then pulses done.
//
// state | meaning
// IDLE  | waiting for i_start; outputs hold last address/data, o_wren low
// WRITE | presenting one write per cycle; advances only when not stalled
// DONE  | single-cycle completion pulse, then back to IDLE
module write_driver
   import pipeline_pkg::*;
#(
   parameter int          ADDR_W    = ADDR_W_DEF,
   parameter int          DATA_W    = DATA_W_DEF,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned NUM_WORDS = 6,
   parameter logic [31:0] DATA_SEED = 32'hA5A5_0000,
   parameter logic [31:0] DATA_STEP = 32'd1
) (
   input  logic              i_CLK,
   input  logic              i_RST_N,
   input  logic              i_start,
   input  logic              i_stall,
   output logic [ADDR_W-1:0] o_wraddr,
   output logic [DATA_W-1:0] o_wrdata,
   output logic              o_wren,
   output logic              o_busy,
   output logic              o_done,
   output logic [3:0]        o_state_HEX0
);

   localparam int                CNT_W = $clog2(NUM_WORDS) + 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
   localparam logic [DATA_W-1:0] SEED  = DATA_W'(DATA_SEED);
   localparam logic [DATA_W-1:0] STEP  = DATA_W'(DATA_STEP);

   state_e            state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [DATA_W-1:0] data, data_nx;
   logic              wren, wren_nx;
   logic [CNT_W-1:0]  count, count_nx;

   always_ff @(posedge i_CLK) begin
      if (!i_RST_N) begin
         state <= ST_IDLE;
         addr  <= '0;
         data  <= '0;
         wren  <= 1'b0;
         count <= '0;
      end else begin
         state <= state_nx;
         addr  <= addr_nx;
         data  <= data_nx;
         wren  <= wren_nx;
         count <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      data_nx  = data;
      wren_nx  = wren;
      count_nx = count;
      case (state)
         ST_IDLE: begin
            wren_nx = 1'b0;
            if (i_start) begin
               state_nx = ST_WRITE;
               addr_nx  = BASE;
               data_nx  = SEED;
               wren_nx  = 1'b1;
               count_nx = '0;
            end
         end
         ST_WRITE: begin
            if (wren && !i_stall) begin
               if (count == LAST) begin
                  state_nx = ST_DONE;
                  wren_nx  = 1'b0;
               end else begin
                  addr_nx  = addr + 1'b1;
                  data_nx  = data + STEP;
                  count_nx = count + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
            wren_nx  = 1'b0;
         end
         default: begin
            state_nx = ST_IDLE;
            wren_nx  = 1'b0;
         end
      endcase
   end

   // Status outputs decode the state register only, so they stay registered.
   assign o_wraddr     = addr;
   assign o_wrdata     = data;
   assign o_wren       = wren;
   assign o_busy       = (state == ST_WRITE);
   assign o_done       = (state == ST_DONE);
   assign o_state_HEX0 = state;

endmodule

// File: tb/tb_write_driver.sv
// Scoreboard bench for write_driver: two instances (default and wrapping
// configuration) share random and directed start/stall/reset stimulus.
module tb_write_driver;

   localparam int          N0 = 6;
   localparam int          N1 = 4;
   localparam logic [4:0]  B0 = 5'd0;
   localparam logic [4:0]  B1 = 5'd30;
   localparam logic [31:0] S0 = 32'hA5A5_0000;
   localparam logic [31:0] S1 = 32'hFFFF_FFFE;

   logic        clk = 1'b0;
   logic        rst_n, start, stall;
   logic [4:0]  addr0, addr1;
   logic [31:0] data0, data1;
   logic        wren0, wren1, busy0, busy1, done0, done1;
   logic [3:0]  st0, st1;

   always #5 clk = ~clk;

   write_driver #(.ADDR_W(5), .DATA_W(32), .BASE_ADDR(0), .NUM_WORDS(N0),
                  .DATA_SEED(S0), .DATA_STEP(32'd1)) dut0 (
      .i_CLK(clk), .i_RST_N(rst_n), .i_start(start), .i_stall(stall),
      .o_wraddr(addr0), .o_wrdata(data0), .o_wren(wren0), .o_busy(busy0),
      .o_done(done0), .o_state_HEX0(st0));

   write_driver #(.ADDR_W(5), .DATA_W(32), .BASE_ADDR(30), .NUM_WORDS(N1),
                  .DATA_SEED(S1), .DATA_STEP(32'd1)) dut1 (
      .i_CLK(clk), .i_RST_N(rst_n), .i_start(start), .i_stall(stall),
      .o_wraddr(addr1), .o_wrdata(data1), .o_wren(wren1), .o_busy(busy1),
      .o_done(done1), .o_state_HEX0(st1));

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t sb_q0[$];
   wr_t sb_q1[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int done_cnt0 = 0;

   // Reference model: phase 0 waiting, 1 writing, 2 completion pulse.
   int          ph[2];
   int          rem[2];
   logic [4:0]  la[2];
   logic [31:0] ld[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out, got no event expected event at %0t", name, $time);
   endtask

   function automatic int p_num(input int k);
      return (k == 0) ? N0 : N1;
   endfunction

   function automatic wr_t entry(input int k, input int i);
      wr_t e;
      int  base;
      base = (k == 0) ? int'(B0) : int'(B1);
      e.a  = 5'((base + i) % 32);
      e.d  = ((k == 0) ? S0 : S1) + 32'(i);
      return e;
   endfunction

   task automatic model_step(input int k);
      wr_t e;
      if (!rst_n) begin
         ph[k] = 0; rem[k] = 0; la[k] = '0; ld[k] = '0;
         if (k == 0) sb_q0.delete(); else sb_q1.delete();
      end else begin
         case (ph[k])
            0: if (start) begin
               ph[k]  = 1;
               rem[k] = p_num(k);
               for (int i = 0; i < p_num(k); i++) begin
                  if (k == 0) sb_q0.push_back(entry(k, i));
                  else        sb_q1.push_back(entry(k, i));
               end
               e = entry(k, 0); la[k] = e.a; ld[k] = e.d;
            end
            1: if (!stall) begin
               rem[k]--;
               if (rem[k] == 0) ph[k] = 2;
               else begin
                  e = entry(k, p_num(k) - rem[k]); la[k] = e.a; ld[k] = e.d;
               end
            end
            default: ph[k] = 0;
         endcase
      end
   endtask

   task automatic monitor_inst(input int k, input logic wr, input logic bz, input logic dn,
                               input logic [3:0] st, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      chk($sformatf("wren%0d", k),  64'(wr), 64'(ph[k] == 1));
      chk($sformatf("busy%0d", k),  64'(bz), 64'(ph[k] == 1));
      chk($sformatf("done%0d", k),  64'(dn), 64'(ph[k] == 2));
      chk($sformatf("state%0d", k), 64'(st), 64'(ph[k]));
      chk($sformatf("addr%0d", k),  64'(a),  64'(la[k]));
      chk($sformatf("data%0d", k),  64'(d),  64'(ld[k]));
      if (wr && !stall && rst_n) begin
         if (((k == 0) ? sb_q0.size() : sb_q1.size()) == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_extra_write%0d: got write to %0h expected none", k, a);
         end else begin
            e = (k == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
            chk($sformatf("sb_addr%0d", k), 64'(a), 64'(e.a));
            chk($sformatf("sb_data%0d", k), 64'(d), 64'(e.d));
         end
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      monitor_inst(0, wren0, busy0, done0, st0, addr0, data0);
      monitor_inst(1, wren1, busy1, done1, st1, addr1, data1);
      if (done0) done_cnt0++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_addr0(input logic [4:0] v);
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (wren0 && addr0 == v) found = 1;
         else tick();
      end
      if (!found) timeout($sformatf("wait_addr0_%0d", v));
   endtask

   task automatic wait_done(input int cs, input int e0, input int e1, input string tag);
      int d0 = -1;
      int d1 = -1;
      for (int i = 0; i < 80 && (d0 < 0 || d1 < 0); i++) begin
         if (done0 && d0 < 0) d0 = cyc - cs + 1;
         if (done1 && d1 < 0) d1 = cyc - cs + 1;
         if (d0 < 0 || d1 < 0) tick();
      end
      chk({tag, "_lat0"}, 64'(d0), 64'(e0));
      chk({tag, "_lat1"}, 64'(d1), 64'(e1));
   endtask

   task automatic pulse_start(output int cs);
      start = 1'b1;
      tick();
      start = 1'b0;
      cs = cyc;
   endtask

   initial begin
      int cs;
      int dc;
      rst_n = 1'b0; start = 1'b0; stall = 1'b0;
      tick(); tick();
      chk("reset_wren0", 64'(wren0), 64'd0);
      chk("reset_state0", 64'(st0), 64'd0);
      rst_n = 1'b1;
      tick();

      // Plain run: done on cycle N+1 counting the start edge as cycle 1.
      pulse_start(cs);
      wait_done(cs, N0 + 1, N1 + 1, "plain");
      repeat (3) tick();

      // Three stall cycles while address 2 is presented.
      pulse_start(cs);
      wait_addr0(5'd2);
      stall = 1'b1;
      repeat (3) begin
         tick();
         chk("stall_hold_addr", 64'(addr0), 64'd2);
         chk("stall_hold_data", 64'(data0), 64'hA5A5_0002);
      end
      stall = 1'b0;
      wait_done(cs, N0 + 4, N1 + 4, "stall");
      repeat (3) tick();

      // Reset mid-run at address 3, then a fresh run from the base.
      pulse_start(cs);
      wait_addr0(5'd3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_wren",  64'(wren0), 64'd0);
      chk("midrst_addr",  64'(addr0), 64'd0);
      chk("midrst_data",  64'(data0), 64'd0);
      chk("midrst_state", 64'(st0),   64'd0);
      tick();
      pulse_start(cs);
      chk("restart_addr", 64'(addr0), 64'd0);
      wait_done(cs, N0 + 1, N1 + 1, "restart");
      repeat (3) tick();

      // Start pulses during WRITE and DONE are ignored.
      dc = done_cnt0;
      pulse_start(cs);
      tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 40 && !done0; i++) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (15) tick();
      chk("ignored_start_dones", 64'(done_cnt0 - dc), 64'd1);
      chk("ignored_start_idle", 64'(st0), 64'd0);

      // Start held high: repeated runs separated by one idle cycle.
      start = 1'b1;
      repeat (20) tick();
      start = 1'b0;
      repeat (15) tick();

      // Random start/stall/reset.
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(3) == 0);
         stall = ($urandom_range(2) == 0);
         rst_n = ($urandom_range(79) != 0);
         tick();
      end
      start = 1'b0; stall = 1'b0; rst_n = 1'b1;
      repeat (20) tick();

      chk("sb_left0", 64'(sb_q0.size()), 64'd0);
      chk("sb_left1", 64'(sb_q1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
